// File: rtl/halfadder_bist_pkg.sv
// rtl/halfadder_bist_pkg.sv - shared types and vector tables for the half adder self-test
package halfadder_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = 2;
  localparam int FAIL_VEC_W  = 4;

  // Bit i holds the operand for vector i: (1,1), (0,1), (1,0), (0,0)
  localparam logic [NUM_VECTORS-1:0] VEC_A = 4'b0101;
  localparam logic [NUM_VECTORS-1:0] VEC_B = 4'b0011;

endpackage

// File: rtl/halfadder_ref.sv
// rtl/halfadder_ref.sv - combinational golden half adder
module halfadder_ref (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/halfadder_bist.sv
// rtl/halfadder_bist.sv - drives all four vectors into an external half adder and checks the results
module halfadder_bist
  import halfadder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  dut_a,
  output logic                  dut_b,
  input  logic                  dut_s,
  input  logic                  dut_c,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  fail_valid,
  output logic [FAIL_VEC_W-1:0] fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  logic             start_q;
  logic             accept;
  logic             ref_s;
  logic             ref_c;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  halfadder_ref u_ref (
    .a (VEC_A[idx]),
    .b (VEC_B[idx]),
    .s (ref_s),
    .c (ref_c)
  );

  // Only meaningful in CHECK; adder outputs are don't-care elsewhere
  assign mismatch = (dut_s != ref_s) || (dut_c != ref_c);
  assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_q) begin
          accept     = 1'b1;
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: state_next = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_WAIT;
      ST_WAIT:  if (settle_cnt == CNT_W'(1)) state_next = ST_CHECK;
      ST_CHECK: state_next = (idx == IDX_W'(NUM_VECTORS - 1)) ? ST_DONE : ST_DRIVE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      idx        <= '0;
      settle_cnt <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      // start is registered once so the run begins one edge after it is sampled
      start_q <= start;
      state   <= state_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            idx        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        ST_DRIVE: begin
          dut_a      <= VEC_A[idx];
          dut_b      <= VEC_B[idx];
          settle_cnt <= CNT_W'(SETTLE_CYCLES);
        end
        ST_WAIT: settle_cnt <= settle_cnt - CNT_W'(1);
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {idx, dut_s, dut_c};
            end
          end
          if (idx == IDX_W'(NUM_VECTORS - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0) && !mismatch;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_halfadder_bist.sv
// tb/tb_halfadder_bist.sv - directed bench for halfadder_bist with faulty and good external adders
module tb_halfadder_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start2;
  int         fault;

  logic       a1, b1, s1, c1;
  logic       busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [3:0] fvec1;

  logic       a2, b2, s2, c2;
  logic       busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [3:0] fvec2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External adders: mode 0 good, 1 sum stuck-at-0, 2 carry inverted
  assign s1 = (fault == 1) ? 1'b0 : (a1 ^ b1);
  assign c1 = (fault == 2) ? ~(a1 & b1) : (a1 & b1);
  assign s2 = a2 ^ b2;
  assign c2 = ~(a2 & b2);

  halfadder_bist #(.SETTLE_CYCLES(2), .ERR_W(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_a      (a1),
    .dut_b      (b1),
    .dut_s      (s1),
    .dut_c      (c1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err1),
    .fail_valid (fv1),
    .fail_vec   (fvec1)
  );

  halfadder_bist #(.SETTLE_CYCLES(0), .ERR_W(2)) u_dut_fast (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .dut_a      (a2),
    .dut_b      (b2),
    .dut_s      (s2),
    .dut_c      (c2),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .err_count  (err2),
    .fail_valid (fv2),
    .fail_vec   (fvec2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
    check({tag, "_pass"}, pass1, 0);
    check({tag, "_err"}, err1, 0);
    check({tag, "_fv"}, fv1, 0);
    check({tag, "_fvec"}, fvec1, 0);
    check({tag, "_a"}, a1, 0);
    check({tag, "_b"}, b1, 0);
  endtask

  // Drives start so that it is sampled at the next edge (edge 0)
  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input int done_edge, input int mid_start_edge);
    for (int k = 1; k <= done_edge; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check({tag, "_done_clear"}, done1, 0);
        check({tag, "_err_clear"}, err1, 0);
      end
      if (k == done_edge - 1) check({tag, "_busy_last"}, busy1, 1);
      if (k == done_edge - 1) check({tag, "_done_early"}, done1, 0);
      if (k == done_edge) check({tag, "_busy_end"}, busy1, 0);
      if (k == done_edge) check({tag, "_done"}, done1, 1);
      if (k == mid_start_edge - 1) start = 1'b1;
      if (k == mid_start_edge) start = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    fault  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Good adder
    start_run();
    run_check("good", 17, 0);
    check("good_pass", pass1, 1);
    check("good_err", err1, 0);
    check("good_fv", fv1, 0);

    // Sum stuck-at-0: idx1 and idx2 fail
    fault = 1;
    start_run();
    run_check("s0", 17, 0);
    check("s0_pass", pass1, 0);
    check("s0_err", err1, 2);
    check("s0_fv", fv1, 1);
    check("s0_fvec", fvec1, 4'b0100);
    check("s0_a_hold", a1, 0);
    check("s0_b_hold", b1, 0);

    // Carry inverted: all four fail
    fault = 2;
    start_run();
    run_check("cinv", 17, 0);
    check("cinv_pass", pass1, 0);
    check("cinv_err", err1, 4);
    check("cinv_fv", fv1, 1);
    check("cinv_fvec", fvec1, 4'b0000);

    // Restart from DONE with a stray start at edge 6
    fault = 0;
    start_run();
    check("restart_done_held", done1, 1);
    run_check("midstart", 17, 6);
    check("midstart_pass", pass1, 1);
    check("midstart_err", err1, 0);

    // Reset during WAIT of idx2
    start_run();
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("wait2_a", a1, 1);
    check("wait2_b", b1, 0);
    check("wait2_busy", busy1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst = 1'b0;
    start_run();
    run_check("postrst", 17, 0);
    check("postrst_pass", pass1, 1);
    check("postrst_fv", fv1, 0);

    // Zero settle, 2-bit saturating error count
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 8) check("fast_done_early", done2, 0);
      if (k == 8) check("fast_busy", busy2, 1);
    end
    check("fast_done", done2, 1);
    check("fast_err_sat", err2, 3);
    check("fast_pass", pass2, 0);
    check("fast_fv", fv2, 1);
    check("fast_fvec", fvec2, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
